// File: rtl/msg_byte_packer.sv
// rtl/msg_byte_packer.sv - packs a byte stream into 32-bit message words; optional MSG_LEN_EN adds a message length counter
module msg_byte_packer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      msg_word,
  output logic             msg_valid,
  output logic             msg_last,
  output logic [2:0]       msg_nbytes,
  input  logic             msg_ready,
  output logic [LEN_W-1:0] msg_len
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [2:0]  nb_q, nb_d;

  logic        accept;
  logic        load;
  logic        xfer;
  logic [31:0] packed_word;

  // A pending word only blocks new bytes while downstream is stalling it
  assign in_ready = !valid_q || msg_ready;
  assign accept   = in_valid && in_ready && !clear;
  assign load     = accept && ((idx_q == 2'd3) || in_last);
  assign xfer     = valid_q && msg_ready;

  assign msg_word   = word_q;
  assign msg_valid  = valid_q;
  assign msg_last   = last_q;
  assign msg_nbytes = nb_q;

  // Completed word: stored lanes below idx, the incoming byte at idx, zeros above
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < idx_q) begin
        packed_word[8*i +: 8] = acc_q[8*i +: 8];
      end else if (2'(i) == idx_q) begin
        packed_word[8*i +: 8] = in_byte;
      end
    end
  end

  // Next-state for accumulator, output register and control state
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    nb_d    = nb_q;

    if (clear) begin
      acc_d   = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else begin
      // Drop valid after a transfer; a same-cycle load below re-asserts it
      if (xfer) begin
        valid_d = 1'b0;
      end
      if (load) begin
        word_d  = packed_word;
        nb_d    = {1'b0, idx_q} + 3'd1;
        last_d  = in_last;
        valid_d = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
      end else if (accept) begin
        acc_d[{idx_q, 3'b000} +: 8] = in_byte;
        idx_d = idx_q + 2'd1;
      end
      if (accept) begin
        state_d = in_last ? ST_IDLE : ST_ACCUM;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      nb_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      nb_q    <= nb_d;
    end
  end

`ifdef MSG_LEN_EN
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
  assign msg_len = len_q;

  // Saturating byte count; published and restarted on the last byte
  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      if (in_last) begin
        len_d = cnt_inc;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Length counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end
`else
  assign msg_len = '0;
`endif

endmodule

// File: tb/tb_msg_byte_packer.sv
// tb/tb_msg_byte_packer.sv - directed self-checking bench for msg_byte_packer
module tb_msg_byte_packer;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [31:0]      msg_word;
  logic             msg_valid;
  logic             msg_last;
  logic [2:0]       msg_nbytes;
  logic             msg_ready;
  logic [LEN_W-1:0] msg_len;

  int errors = 0;
  int checks = 0;
  int stalls = 0;

  logic [31:0] q_word[$];
  logic        q_last[$];
  logic [2:0]  q_nb[$];

  always #5 clk = ~clk;

  msg_byte_packer #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .msg_word   (msg_word),
    .msg_valid  (msg_valid),
    .msg_last   (msg_last),
    .msg_nbytes (msg_nbytes),
    .msg_ready  (msg_ready),
    .msg_len    (msg_len)
  );

  // Record every word that will transfer on the coming posedge
  always @(negedge clk) begin
    if (!reset && !clear && msg_valid && msg_ready) begin
      q_word.push_back(msg_word);
      q_last.push_back(msg_last);
      q_nb.push_back(msg_nbytes);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = l;
    #1;
    if (!in_ready) stalls++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic flush_q();
    q_word.delete();
    q_last.delete();
    q_nb.delete();
  endtask

  task automatic check_word(input int k, input logic [31:0] w, input logic l, input logic [2:0] nb);
    checks++;
    if (q_word.size() <= k) begin
      errors++;
      $display("FAIL word%0d_present: got %0d words required more than %0d", k, q_word.size(), k);
    end else if (q_word[k] !== w || q_last[k] !== l || q_nb[k] !== nb) begin
      errors++;
      $display("FAIL word%0d: got %h last=%b nb=%0d required %h last=%b nb=%0d",
               k, q_word[k], q_last[k], q_nb[k], w, l, nb);
    end
  endtask

  task automatic check_count(input string name, input int n);
    checks++;
    if (q_word.size() !== n) begin
      errors++;
      $display("FAIL %s_count: got %0d words required %0d", name, q_word.size(), n);
    end
  endtask

  task automatic check_len(input string name, input logic [LEN_W-1:0] exp_len);
    checks++;
`ifdef MSG_LEN_EN
    if (msg_len !== exp_len) begin
      errors++;
      $display("FAIL %s_len: got %0d required %0d", name, msg_len, exp_len);
    end
`else
    if (msg_len !== '0) begin
      errors++;
      $display("FAIL %s_len: got %0d required 0 (exp %0d when enabled)", name, msg_len, exp_len);
    end
`endif
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || msg_valid !== 1'b0 || msg_word !== 32'h0 ||
        msg_last !== 1'b0 || msg_nbytes !== 3'd0 || msg_len !== '0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b w=%h l=%b nb=%0d len=%0d required 1 0 0 0 0 0",
               in_ready, msg_valid, msg_word, msg_last, msg_nbytes, msg_len);
    end
  endtask

  task automatic test_two_words();
    logic [7:0] bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    flush_q();
    stalls = 0;
    msg_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7);
    step();
    checks++;
    if (stalls !== 0) begin
      errors++;
      $display("FAIL two_words_stall: got %0d stall cycles required 0", stalls);
    end
    check_count("two_words", 2);
    check_word(0, 32'h44332211, 1'b0, 3'd4);
    check_word(1, 32'h88776655, 1'b1, 3'd4);
    check_len("two_words", 16'd8);
  endtask

  task automatic test_partial();
    flush_q();
    msg_ready = 1'b1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    checks++;
    if (msg_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_early: got msg_valid=%b required 0", msg_valid);
    end
    send_byte(8'hCC, 1'b1);
    checks++;
    if (msg_valid !== 1'b1 || msg_word !== 32'h00CCBBAA || msg_nbytes !== 3'd3 || msg_last !== 1'b1) begin
      errors++;
      $display("FAIL partial_latency: got v=%b w=%h nb=%0d l=%b required 1 00ccbbaa 3 1",
               msg_valid, msg_word, msg_nbytes, msg_last);
    end
    step();
    check_count("partial", 1);
    check_len("partial", 16'd3);
  endtask

  task automatic test_single();
    flush_q();
    msg_ready = 1'b1;
    send_byte(8'h5A, 1'b1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    step();
    check_count("single", 2);
    check_word(0, 32'h0000005A, 1'b1, 3'd1);
    check_word(1, 32'h04030201, 1'b1, 3'd4);
    check_len("single", 16'd4);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    flush_q();
    msg_ready = 1'b1;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    msg_ready = 1'b0;
    send_byte(8'hA4, 1'b0);
    held = 32'hA4A3A2A1;
    in_byte  = 8'hB1;
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || msg_valid !== 1'b1 || msg_word !== held || msg_nbytes !== 3'd4) begin
        errors++;
        $display("FAIL stall_cycle%0d: got rdy=%b v=%b w=%h nb=%0d required 0 1 %h 4",
                 k, in_ready, msg_valid, msg_word, msg_nbytes, held);
      end
      step();
    end
    msg_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_byte(8'hB4, 1'b1);
    step();
    check_count("backpressure", 2);
    check_word(0, 32'hA4A3A2A1, 1'b0, 3'd4);
    check_word(1, 32'hB4B3B2B1, 1'b1, 3'd4);
    check_len("backpressure", 16'd8);
  endtask

  task automatic test_clear();
    flush_q();
    msg_ready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    clear    = 1'b1;
    in_byte  = 8'hEE;
    in_valid = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b1);
    step();
    check_count("clear", 1);
    check_word(0, 32'h06050403, 1'b1, 3'd4);
    check_len("clear", 16'd4);
  endtask

  task automatic test_reset_mid();
    flush_q();
    msg_ready = 1'b0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (msg_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got v=%b rdy=%b required 0 1", msg_valid, in_ready);
    end
    step();
    reset = 1'b0;
    msg_ready = 1'b1;
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    send_byte(8'hE3, 1'b1);
    step();
    check_count("reset_mid", 1);
    check_word(0, 32'h00E3E2E1, 1'b1, 3'd3);
    check_len("reset_mid", 16'd3);
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_byte   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    msg_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    test_reset();
    test_two_words();
    test_partial();
    test_single();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
